mac_inverse_divider: RTL
========================

# mac_inverse_divider

Inverse of the three-stage add→multiply→accumulate datapath: given a MAC result `y`, accumulator `acc`, multiplier `c` and addend `b`, it recovers `a = ((y - acc) / c) - b` with an iterative restoring divider. It also reports the division remainder and a divide-by-zero flag. It sits beside the MAC benchmarks as the round-trip checker and reference "other direction" datapath. It uses valid/ready handshakes on input and output and processes one operation at a time.

## Interface

- `WIDTH`, 16, data width of all operands and results.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operand set is valid.
- `in_ready`  output  1  block can accept an operand set.
- `y`  input  WIDTH  MAC output value.
- `acc`  input  WIDTH  accumulator term.
- `c`  input  WIDTH  divisor (the MAC multiplier).
- `b`  input  WIDTH  addend to remove.
- `out_valid`  output  1  result is valid.
- `out_ready`  input  1  consumer accepts the result.
- `a`  output  WIDTH  recovered operand.
- `rem`  output  WIDTH  remainder of `(y - acc) / c`.
- `div_by_zero`  output  1  `c` was 0 for this result.

## Operation

- All arithmetic is unsigned modulo 2^WIDTH.
  - `diff = y - acc` (wraps).
  - `q = diff / c` and `r = diff % c`.
  - `a = q - b` (wraps).
- The FSM has four states: IDLE, DIV, FIN, DONE.
  - IDLE: `in_ready` = 1. On `in_valid && in_ready`, register `diff`, `c`, `b` and `div_by_zero = (c == 0)`, clear the partial remainder and the iteration counter, then go to DIV.
  - DIV: one restoring step per cycle, MSB first.
    - Shift the next `diff` bit into the partial remainder.
    - If remainder ≥ `c`, subtract `c` and set the quotient bit to 1; otherwise set it to 0.
    - After WIDTH steps, go to FIN.
  - FIN: register `a = q - b` and `rem = r`, then go to DONE.
  - DONE: `out_valid` = 1. On `out_ready`, go to IDLE.
- `in_ready` is high only in IDLE. A new operand set is never accepted in the same cycle a result is consumed.
- Divide-by-zero needs no special datapath. The restoring algorithm naturally yields `q = all-ones` and `r = diff`, and latency is unchanged.
- `a`, `rem` and `div_by_zero` hold stable from `out_valid` rising until the handshake completes. They keep their values afterwards until the next FIN.
- Input operands are sampled only on the accept edge. Later changes are ignored.

## Timing

- Reset (async assert, sync deassert by the integration):
  - State goes to IDLE.
  - `in_ready` = 1, `out_valid` = 0, `a` = 0, `rem` = 0, `div_by_zero` = 0.
  - The counter and partial remainder are cleared.
- Latency: let the accept edge be E0. DIV steps occur on E1..E{WIDTH}, FIN is registered on E{WIDTH+1}, and `out_valid` goes high after E{WIDTH+1`}. That is 17 cycles for WIDTH = 16.
- Minimum issue interval with `out_ready` tied high is WIDTH + 3 = 19 cycles: accept, WIDTH × DIV, FIN, DONE, IDLE.
- Backpressure: DONE is held indefinitely while `out_ready` = 0. No results are dropped or overwritten.
- `rst_n` asserted mid-DIV or mid-DONE aborts immediately. The in-flight result is discarded and is never presented.
- `out_ready` is ignored outside DONE. `in_valid` is ignored outside IDLE.

## Test plan

- Round trip: y=100, acc=10, c=9, b=3. Required: a=7, rem=0, div_by_zero=0, with `out_valid` exactly 17 cycles after accept.
- Nonzero remainder: y=100, acc=0, c=7, b=0. Required: a=14, rem=2.
- Wraparound: y=5, acc=10, c=1, b=0. Required: diff=65531, so a=65531, rem=0. Also y=9, acc=0, c=3, b=5. Required: a=65534.
- Divide-by-zero: y=50, acc=0, c=0, b=1. Required: a=0xFFFE, rem=50, div_by_zero=1, same 17-cycle latency.
- Backpressure and throughput:
  - Hold `out_ready` = 0 for 5 cycles in DONE. Required: outputs stable, `in_ready` = 0, and `in_valid` pulses are ignored.
  - Then release `out_ready` and drive back-to-back valid inputs. Required: accepts spaced exactly 19 cycles apart.
- Reset mid-operation: assert `rst_n` = 0 at DIV step 8. Required: `out_valid` = 0 and `in_ready` = 1 immediately (asynchronously), all outputs 0, and the next operation completes correctly.

Source files
------------

// File: rtl/mac_inverse_divider_if.sv
// Operand/result handshake bundle for mac_inverse_divider: valid/ready input side
// carrying y/acc/c/b, valid/ready output side carrying a/rem/div_by_zero.
interface mac_inverse_divider_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] rem;
  logic             div_by_zero;

  modport master (
    output in_valid, y, acc, c, b, out_ready,
    input  in_ready, out_valid, a, rem, div_by_zero
  );

  modport slave (
    input  in_valid, y, acc, c, b, out_ready,
    output in_ready, out_valid, a, rem, div_by_zero
  );
endinterface

// File: rtl/mac_inverse_divider.sv
// Recovers a = ((y - acc) / c) - b with a one-bit-per-cycle restoring divider,
// also reporting the remainder and whether c was zero.
module mac_inverse_divider #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mac_inverse_divider_if.slave  io
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, DIV, FIN, DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] dq_q;      // dividend bits shift out the top, quotient bits fill the bottom
  logic [WIDTH-1:0] c_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] prem_q;
  logic             dbz_pend_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] prem_d;
  logic [WIDTH-1:0] dq_d;

  // The shifted remainder needs one extra bit; when it fits, the difference is below c.
  always_comb begin
    shifted = {prem_q, dq_q[WIDTH-1]};
    fits    = (shifted >= {1'b0, c_q});
    prem_d  = fits ? (shifted[WIDTH-1:0] - c_q) : shifted[WIDTH-1:0];
    dq_d    = {dq_q[WIDTH-2:0], fits};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dq_q        <= '0;
      c_q         <= '0;
      b_q         <= '0;
      prem_q      <= '0;
      dbz_pend_q  <= 1'b0;
      a_q         <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (io.in_valid) begin
            dq_q       <= io.y - io.acc;
            c_q        <= io.c;
            b_q        <= io.b;
            dbz_pend_q <= (io.c == '0);
            prem_q     <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= DIV;
          end
        end
        DIV: begin
          prem_q <= prem_d;
          dq_q   <= dq_d;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          a_q         <= dq_q - b_q;
          rem_q       <= prem_q;
          dbz_q       <= dbz_pend_q;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.in_ready    = in_ready_q;
  assign io.out_valid   = out_valid_q;
  assign io.a           = a_q;
  assign io.rem         = rem_q;
  assign io.div_by_zero = dbz_q;
endmodule
